// File: rtl/reg_bank_dump.sv
// Read-only dump engine: walks a dual-read-port register bank two registers at a time
// and presents each {odd, even} pair on a valid/ready output until the whole bank is emitted.
module reg_bank_dump #(
  parameter  int WIDTH      = 32,
  parameter  int TOTAL_REGS = 32,
  localparam int AW         = $clog2(TOTAL_REGS),
  localparam int PW         = (AW > 1) ? AW - 1 : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [AW-1:0]      RA1,
  output logic [AW-1:0]      RA2,
  input  logic [WIDTH-1:0]   RD1,
  input  logic [WIDTH-1:0]   RD2,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] OUT_DATA,
  output logic [AW-1:0]      OUT_IDX,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_HOLD   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [PW-1:0] LAST_PAIR = PW'(TOTAL_REGS / 2 - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PW-1:0]        r_p;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_out_data;
  logic [AW-1:0]        r_out_idx;
  logic [AW-1:0]        w_ra1;
  logic                 w_p_clr;
  logic                 w_p_inc;
  logic                 w_capture;
  logic                 w_valid_clr;

  // Both read addresses are pure functions of the pair counter.
  assign w_ra1     = AW'({r_p, 1'b0});
  assign RA1       = w_ra1;
  assign RA2       = w_ra1 | AW'(1);
  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_out_data;
  assign OUT_IDX   = r_out_idx;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_FINISH);

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_p_clr     = 1'b0;
    w_p_inc     = 1'b0;
    w_capture   = 1'b0;
    w_valid_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_p_clr     = 1'b1;
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // OUT_VALID is always set in HOLD, so READY here is an accept.
        if (OUT_READY) begin
          w_valid_clr = 1'b1;
          if (r_p == LAST_PAIR) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_p_inc     = 1'b1;
            w_state_nxt = S_READ;
          end
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_FINISH: begin
        w_p_clr     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pair counter and output pair registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_p_clr) begin
        r_p <= '0;
      end else if (w_p_inc) begin
        r_p <= r_p + PW'(1);
      end
      if (w_capture) begin
        r_out_data  <= {RD2, RD1};
        r_out_idx   <= w_ra1;
        r_out_valid <= 1'b1;
      end else if (w_valid_clr) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/reg_bank_dump.md
REG_BANK_DUMP -- requirements
Module: reg_bank_dump

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register data width in bits.
REQ-002 SHALL have parameter TOTAL_REGS, default 32: register count (even power of two, >=2); AW = $clog2(TOTAL_REGS).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  request full-bank dump; sampled only in IDLE.
REQ-006 SHALL have port RA1  output  AW  even register address to reg_bank read port 1.
REQ-007 SHALL have port RA2  output  AW  odd register address to reg_bank read port 2.
REQ-008 SHALL have port RD1  input  WIDTH  combinational read data for RA1.
REQ-009 SHALL have port RD2  input  WIDTH  combinational read data for RA2.
REQ-010 SHALL have port OUT_VALID  output  1  OUT_DATA/OUT_IDX hold a valid pair.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts the pair when high with OUT_VALID.
REQ-012 SHALL have port OUT_DATA  output  2*WIDTH  {RD2, RD1} captured for the current pair.
REQ-013 SHALL have port OUT_IDX  output  AW  even register index of OUT_DATA low half.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse after the last pair is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, READ, HOLD, FINISH.
REQ-017 SHALL keep pair counter P (AW-1 bits); RA1 = {P,1'b0}, RA2 = {P,1'b1} continuously.
REQ-018 IDLE: START=1 SHALL clear P to 0 and move to READ next edge; START=0 stays IDLE.
REQ-019 READ: SHALL register {RD2,RD1} into OUT_DATA, {P,1'b0} into OUT_IDX, set OUT_VALID=1, move to HOLD (one cycle in READ).
REQ-020 HOLD: OUT_VALID=1; OUT_DATA, OUT_IDX SHALL stay stable while OUT_READY=0.
REQ-021 HOLD with OUT_READY=1: SHALL clear OUT_VALID; if P = TOTAL_REGS/2-1 go FINISH, else increment P and go READ.
REQ-022 FINISH: SHALL assert DONE for exactly one cycle and return to IDLE; P resets to 0.
REQ-023 Throughput SHALL be one pair per 2 cycles with OUT_READY held high; first OUT_VALID 2 cycles after START sampled.
REQ-024 START while BUSY=1 SHALL be ignored (no restart, no queueing).
REQ-025 OUT_READY while OUT_VALID=0 SHALL have no effect.
REQ-026 P SHALL never wrap during a dump; exactly TOTAL_REGS/2 pairs emitted per START.
REQ-027 OUT_DATA SHALL not change outside READ; OUT_IDX increments by 2 per accepted pair.
REQ-028 Block SHALL never drive reg_bank WE3/RA3/WD3 (read-only master).

Reset
REQ-029 RST=1 at a rising edge SHALL force IDLE, P=0, OUT_VALID=0, OUT_DATA=0, OUT_IDX=0, DONE=0, BUSY=0, hence RA1=0, RA2=1.
REQ-030 RST SHALL take priority over START and OUT_READY in the same cycle.
REQ-031 RST mid-dump SHALL abort immediately; no DONE pulse; next START begins at pair 0.

Verification
REQ-032 Preload reg_bank r[i]=100+i via WE3, START pulse, OUT_READY=1 -> 16 transfers, OUT_IDX 0,2,..,30, OUT_DATA = {101+2k, 100+2k}, DONE once, 32 cycles START-to-DONE-ish per REQ-023.
REQ-033 OUT_READY=0 for 5 cycles during pair 3 -> OUT_DATA={107,106}, OUT_IDX=6 stable across all 5 cycles, no pair lost or duplicated.
REQ-034 START pulsed again at pair 8 -> ignored; sequence continues to pair 15, single DONE.
REQ-035 RST asserted during pair 5 HOLD -> next cycle OUT_VALID=0, BUSY=0, RA1=0, RA2=1, no DONE; fresh START restarts from OUT_IDX=0.
REQ-036 Random OUT_READY (50%) over full dump -> scoreboard matches all 16 pairs in order; BUSY high from cycle after START until DONE cycle inclusive.
REQ-037 Reset release with START=0 for 10 cycles -> BUSY=0, OUT_VALID=0, DONE=0 throughout.
